// File: rtl/mcpu_pkg.sv
// mcpu_pkg: sequencer state encodings, opcode/func constants and the reset PC shared by the CPU blocks.
package mcpu_pkg;
  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE1 = 3'b110,
    S_EXE2 = 3'b101,
    S_EXE3 = 3'b010,
    S_WB1  = 3'b111,
    S_WB2  = 3'b100,
    S_MEM  = 3'b011
  } state_e;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BLTZ  = 6'b000001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_HALT  = 6'b111111;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  function automatic logic [31:0] branch_off(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction
endpackage

// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: sequencer/datapath-facing signals of the fetch unit.
interface pc_fetch_unit_if;
  import mcpu_pkg::*;
  state_e      state;
  logic [31:0] instr_in;
  logic        zero;
  logic        sign;
  logic [31:0] rs_data;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] ir;
  logic        ra_we;
  logic [31:0] ra_data;
  logic        halted;
  logic [31:0] retired_cnt;
  modport slave (input state, instr_in, zero, sign, rs_data,
                 output pc, pc_plus4, ir, ra_we, ra_data, halted, retired_cnt);
  modport master (output state, instr_in, zero, sign, rs_data,
                  input pc, pc_plus4, ir, ra_we, ra_data, halted, retired_cnt);
endinterface

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational next-PC selection and PC write enable for the current sequencer state.
module pc_next_sel import mcpu_pkg::*; (
  input  state_e      state,
  input  logic [31:0] ir,
  input  logic        zero,
  input  logic        sign,
  input  logic [31:0] rs_data,
  input  logic [31:0] pc,
  output logic [31:0] next_pc,
  output logic        pc_we
);
  logic [31:0] pc4;
  logic [5:0]  op;
  logic        jmp, jr, exe2, seq, taken;
  always_comb begin
    pc4     = pc + 32'd4;
    op      = ir[31:26];
    jmp     = state == S_ID && (op == OP_J || op == OP_JAL);
    jr      = state == S_ID && op == OP_RTYPE && ir[5:0] == FN_JR;
    exe2    = state == S_EXE2;
    seq     = state == S_WB1 || state == S_WB2 || (state == S_MEM && op == OP_SW);
    taken   = (op == OP_BEQ && zero) || (op == OP_BNE && !zero) || (op == OP_BLTZ && sign);
    pc_we   = jmp || jr || exe2 || seq;
    next_pc = jmp ? {pc4[31:28], ir[25:0], 2'b00} :
              jr ? (rs_data & ~32'd3) :
              (exe2 && taken) ? pc4 + branch_off(ir[15:0]) : pc4;
  end
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC/IR registers, jal link write and sticky halt of the multi-cycle CPU.
// Optional retired-instruction counter enabled by defining PERF_CNT_EN.
module pc_fetch_unit import mcpu_pkg::*; #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic clk,
  input  logic Reset,
  pc_fetch_unit_if.slave bus
);
  logic [31:0] pc_q, pc_d, ir_q, ir_d, ra_data_q, ra_data_d, next_pc;
  logic        halted_q, halted_d, ra_we_q, ra_we_d, pc_we, halt_now, in_id;
  pc_next_sel u_sel (
    .state(bus.state), .ir(ir_q), .zero(bus.zero), .sign(bus.sign),
    .rs_data(bus.rs_data), .pc(pc_q), .next_pc(next_pc), .pc_we(pc_we)
  );
  always_comb begin
    in_id     = !halted_q && bus.state == S_ID;
    halt_now  = in_id && ir_q[31:26] == OP_HALT;
    pc_d      = (pc_we && !halted_q) ? next_pc : pc_q;
    ir_d      = (!halted_q && bus.state == S_IF) ? bus.instr_in : ir_q;
    halted_d  = halted_q || halt_now;
    ra_we_d   = in_id && ir_q[31:26] == OP_JAL;
    // the link value must be captured before pc moves to the jump target
    ra_data_d = ra_we_d ? pc_q + 32'd4 : ra_data_q;
  end
  always_ff @(posedge clk or negedge Reset)
    if (!Reset) begin
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      halted_q  <= 1'b0;
      ra_we_q   <= 1'b0;
      ra_data_q <= '0;
    end else begin
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      halted_q  <= halted_d;
      ra_we_q   <= ra_we_d;
      ra_data_q <= ra_data_d;
    end
`ifdef PERF_CNT_EN
  logic [31:0] cnt_q, cnt_d;
  always_comb cnt_d = cnt_q + {31'd0, (pc_we && !halted_q) || halt_now};
  always_ff @(posedge clk or negedge Reset)
    if (!Reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign bus.retired_cnt = cnt_q;
`else
  assign bus.retired_cnt = 32'h0;
`endif
  assign bus.pc       = pc_q;
  assign bus.pc_plus4 = pc_q + 32'd4;
  assign bus.ir       = ir_q;
  assign bus.ra_we    = ra_we_q;
  assign bus.ra_data  = ra_data_q;
  assign bus.halted   = halted_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed checks of pc_fetch_unit; state driven on negedge, outputs sampled 1ns after posedge.
module tb_pc_fetch_unit;
  import mcpu_pkg::*;
  logic clk = 1'b0;
  logic Reset = 1'b0;
  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;
`ifdef PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  pc_fetch_unit_if bus ();
  pc_fetch_unit dut (.clk(clk), .Reset(Reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_cnt(input string tag);
    chk(tag, bus.retired_cnt, PERF ? exp_cnt : 32'd0);
  endtask
  task automatic step(input state_e s);
    @(negedge clk);
    bus.state = s;
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.state = S_IF; bus.instr_in = '0; bus.zero = 1'b0; bus.sign = 1'b0; bus.rs_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_pc4", bus.pc_plus4, 32'h4);
    chk("rst_ir", bus.ir, 32'h0);
    chk("rst_ra_we", {31'd0, bus.ra_we}, 32'h0);
    chk("rst_halted", {31'd0, bus.halted}, 32'h0);
    chk_cnt("rst_cnt");
    @(negedge clk); Reset = 1'b1;
    // addi: IF, ID, EXE1, WB1
    bus.instr_in = 32'h2001_0005; step(S_IF);
    chk("if_ir", bus.ir, 32'h2001_0005);
    chk("if_pc", bus.pc, 32'h0);
    step(S_ID); step(S_EXE1);
    chk("exe1_hold", bus.pc, 32'h0);
    step(S_WB1); exp_cnt++;
    chk("wb1_pc", bus.pc, 32'h4);
    chk_cnt("cnt_wb1");
    // j to 0x40, beq taken back to 0x3C
    bus.instr_in = 32'h0800_0010; step(S_IF); step(S_ID); exp_cnt++;
    chk("j_pc", bus.pc, 32'h40);
    bus.instr_in = 32'h1022_FFFE; step(S_IF); step(S_ID);
    chk("beq_id_hold", bus.pc, 32'h40);
    step(S_EXE1); bus.zero = 1'b1; step(S_EXE2); exp_cnt++;
    chk("beq_taken", bus.pc, 32'h3C);
    bus.instr_in = 32'h0800_0010; step(S_IF); step(S_ID); exp_cnt++;
    bus.instr_in = 32'h1022_FFFE; step(S_IF); step(S_ID); step(S_EXE1);
    bus.zero = 1'b0; step(S_EXE2); exp_cnt++;
    chk("beq_not_taken", bus.pc, 32'h44);
    bus.instr_in = 32'h1422_0001; step(S_IF); step(S_ID); step(S_EXE2); exp_cnt++;
    chk("bne_taken", bus.pc, 32'h4C);
    bus.instr_in = 32'h0420_FFFF; bus.sign = 1'b1; step(S_IF); step(S_ID); step(S_EXE2); exp_cnt++;
    chk("bltz_taken", bus.pc, 32'h4C);
    bus.sign = 1'b0; step(S_EXE2); exp_cnt++;
    chk("bltz_not_taken", bus.pc, 32'h50);
    chk_cnt("cnt_branches");
    // jr to 0x1000_0010, then jal
    bus.instr_in = 32'h0020_0008; bus.rs_data = 32'h1000_0010; step(S_IF); step(S_ID); exp_cnt++;
    chk("jr_pc", bus.pc, 32'h1000_0010);
    bus.instr_in = 32'h0C00_0100; step(S_IF);
    chk("jal_pre_we", {31'd0, bus.ra_we}, 32'h0);
    step(S_ID); exp_cnt++;
    chk("jal_pc", bus.pc, 32'h1000_0400);
    chk("jal_ra_we", {31'd0, bus.ra_we}, 32'h1);
    chk("jal_ra_data", bus.ra_data, 32'h1000_0014);
    step(S_EXE1);
    chk("jal_ra_we_drop", {31'd0, bus.ra_we}, 32'h0);
    chk("jal_exe1_hold", bus.pc, 32'h1000_0400);
    bus.instr_in = 32'h0020_0008; bus.rs_data = 32'h0000_0203; step(S_IF); step(S_ID); exp_cnt++;
    chk("jr_align", bus.pc, 32'h0000_0200);
    // lw holds in MEM, sw advances
    bus.instr_in = 32'h8C22_0000; step(S_IF); step(S_ID); step(S_MEM);
    chk("lw_mem_hold", bus.pc, 32'h200);
    step(S_EXE3);
    chk("exe3_hold", bus.pc, 32'h200);
    bus.instr_in = 32'hAC22_0000; step(S_IF); step(S_MEM); exp_cnt++;
    chk("sw_mem", bus.pc, 32'h204);
    step(S_WB2); exp_cnt++;
    chk("wb2_pc", bus.pc, 32'h208);
    chk_cnt("cnt_mem");
    // wrap at top of address space
    bus.instr_in = 32'h0020_0008; bus.rs_data = 32'hFFFF_FFFF; step(S_IF); step(S_ID); exp_cnt++;
    chk("jr_top", bus.pc, 32'hFFFF_FFFC);
    chk("pc4_wrap", bus.pc_plus4, 32'h0);
    step(S_WB1); exp_cnt++;
    chk("pc_wrap", bus.pc, 32'h0);
    // halt
    bus.instr_in = 32'hFC00_0000; step(S_IF); step(S_ID); exp_cnt++;
    chk("halted", {31'd0, bus.halted}, 32'h1);
    chk("halt_pc_hold", bus.pc, 32'h0);
    chk_cnt("cnt_halt");
    bus.instr_in = 32'h0C00_0100; step(S_IF);
    chk("halt_ir_frozen", bus.ir, 32'hFC00_0000);
    step(S_WB1); step(S_ID);
    chk("halt_pc_frozen", bus.pc, 32'h0);
    chk("halt_ra_we", {31'd0, bus.ra_we}, 32'h0);
    chk_cnt("cnt_halt_frozen");
    #2 Reset = 1'b0; #1;
    exp_cnt = 0;
    chk("rst_async_halted", {31'd0, bus.halted}, 32'h0);
    chk("rst_async_ir", bus.ir, 32'h0);
    @(negedge clk); Reset = 1'b1;
    // add, sw, j then reset in the middle of EXE1
    bus.instr_in = 32'h0022_1820; step(S_IF); step(S_ID); step(S_EXE1); step(S_WB1); exp_cnt++;
    bus.instr_in = 32'hAC22_0000; step(S_IF); step(S_ID); step(S_EXE1); step(S_MEM); exp_cnt++;
    bus.instr_in = 32'h0800_0020; step(S_IF); step(S_ID); exp_cnt++;
    chk("perf_pc", bus.pc, 32'h80);
    chk_cnt("perf_cnt3");
    bus.instr_in = 32'h0022_1820; step(S_IF); step(S_ID); step(S_EXE1);
    #2 Reset = 1'b0; #1;
    exp_cnt = 0;
    chk_cnt("perf_rst_mid");
    chk("rst_mid_pc", bus.pc, 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
